// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU/ALU_Control pair between two requesters.
// Captures the granted operation, holds ALU inputs for LAT cycles, returns the registered result.
module alu_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_aluop,
    input  logic [7:0]         req_funct,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic [1:0]         alu_aluop,
    output logic [3:0]         alu_funct,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_zero
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       aluop_q, aluop_d;
    logic [3:0]       funct_q, funct_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic [1:0] grant;
    logic       grant_idx;
    logic       accept;

    // Contested grant goes to the requester that did not win last time.
    always_comb begin
        grant = '0;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    assign req_ready = (state_q == IDLE && !reset) ? grant : '0;
    assign grant_idx = grant[1];
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        aluop_d  = aluop_q;
        funct_d  = funct_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    aluop_d = grant_idx ? req_aluop[3:2] : req_aluop[1:0];
                    funct_d = grant_idx ? req_funct[7:4] : req_funct[3:0];
                    a_d     = grant_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                    b_d     = grant_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(LAT - 1)) begin
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            aluop_q  <= '0;
            funct_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            aluop_q  <= aluop_d;
            funct_q  <= funct_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign alu_aluop  = aluop_q;
    assign alu_funct  = funct_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: LAT=1 and LAT=3 instances, behavioural ALU,
// expected results queued at grant time and compared when the response appears.
module tb_alu_share_arbiter;

    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset;
    always #5 clk = ~clk;

    logic [1:0]     req_valid, req_ready, req_valid3, req_ready3;
    logic [3:0]     req_aluop;
    logic [7:0]     req_funct;
    logic [2*W-1:0] req_a, req_b;
    logic [1:0]     alu_aluop, alu_aluop3;
    logic [3:0]     alu_funct, alu_funct3;
    logic [W-1:0]   alu_a, alu_b, alu_a3, alu_b3;
    logic [W-1:0]   alu_result, alu_result3;
    logic           alu_zero, alu_zero3;
    logic [1:0]     rsp_valid, rsp_ready, rsp_valid3, rsp_ready3;
    logic [W-1:0]   rsp_result, rsp_result3;
    logic           rsp_zero, rsp_zero3;

    function automatic logic [W:0] alu_model(input logic [1:0] op, input logic [3:0] f,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            2'b00: r = a + b;
            2'b01: r = a - b;
            default: begin
                case (f)
                    4'b0000: r = a & b;
                    4'b0001: r = a | b;
                    4'b0110: r = a - b;
                    default: r = a + b;
                endcase
            end
        endcase
        return {(r == '0), r};
    endfunction

    assign {alu_zero, alu_result}   = alu_model(alu_aluop, alu_funct, alu_a, alu_b);
    assign {alu_zero3, alu_result3} = alu_model(alu_aluop3, alu_funct3, alu_a3, alu_b3);

    alu_share_arbiter #(.WIDTH(W), .LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_aluop(alu_aluop), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    alu_share_arbiter #(.WIDTH(W), .LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_aluop(req_aluop), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_aluop(alu_aluop3), .alu_funct(alu_funct3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_result(alu_result3), .alu_zero(alu_zero3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_zero(rsp_zero3)
    );

    typedef struct {
        logic         owner;
        logic [W-1:0] res;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   tests = 0;
    int   fails = 0;
    bit   ok;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] f,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_aluop[i*2 +: 2] = op;
        req_funct[i*4 +: 4] = f;
        req_a[i*W +: W]     = a;
        req_b[i*W +: W]     = b;
    endtask

    task automatic push_exp(input int g);
        exp_t e;
        e.owner = g[0];
        {e.zero, e.res} = alu_model(req_aluop[g*2 +: 2], req_funct[g*4 +: 4],
                                    req_a[g*W +: W], req_b[g*W +: W]);
        sb.push_back(e);
    endtask

    task automatic wait_rsp(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_rsp(input string tag, input bit found);
        chk({tag, "_arrived"}, W'(found), W'(1));
        chk({tag, "_sb_nonempty"}, W'(sb.size() > 0), W'(1));
        if (sb.size() > 0) begin
            last_e = sb.pop_front();
            chk({tag, "_valid"}, W'(rsp_valid), last_e.owner ? W'(2) : W'(1));
            chk({tag, "_result"}, rsp_result, last_e.res);
            chk({tag, "_zero"}, W'(rsp_zero), W'(last_e.zero));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b11;
        req_valid3 = 2'b00;
        rsp_ready  = 2'b00;
        rsp_ready3 = 2'b00;
        req_aluop  = '0;
        req_funct  = '0;
        req_a      = '0;
        req_b      = '0;
        set_req(0, 2'b00, 4'b0000, 64'd10, 64'd20);
        set_req(1, 2'b01, 4'b0000, 64'd100, 64'd1);

        repeat (2) @(negedge clk);
        chk("rst_req_ready", W'(req_ready), W'(0));
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_rsp_result", rsp_result, W'(0));
        chk("rst_rsp_zero", W'(rsp_zero), W'(0));
        chk("rst_alu_aluop", W'(alu_aluop), W'(0));
        chk("rst_alu_funct", W'(alu_funct), W'(0));
        chk("rst_alu_a", alu_a, W'(0));
        chk("rst_alu_b", alu_b, W'(0));

        // Both requesters valid from reset release: grants must alternate starting at req0.
        @(posedge clk); #1;
        reset     = 1'b0;
        rsp_ready = 2'b11;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("fair_grant", W'(req_ready), (k % 2 == 1) ? W'(2) : W'(1));
            push_exp(k % 2);
            wait_rsp(6, ok);
            check_rsp("fair", ok);
            @(negedge clk);
        end

        req_valid = 2'b01;
        rsp_ready = 2'b00;
        set_req(0, 2'b00, 4'b0010, 64'd5, 64'd3);
        #1;
        chk("single_grant", W'(req_ready), W'(1));
        push_exp(0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_alu_a", alu_a, W'(5));
        chk("single_alu_b", alu_b, W'(3));
        chk("single_alu_aluop", W'(alu_aluop), W'(0));
        chk("single_exec_rsp_valid", W'(rsp_valid), W'(0));
        chk("single_exec_ready", W'(req_ready), W'(0));
        @(negedge clk);
        check_rsp("single", 1'b1);
        chk("single_result_8", rsp_result, W'(8));
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("single_rsp_drop", W'(rsp_valid), W'(0));
        chk("single_alu_a_hold", alu_a, W'(5));

        // Backpressure on req1's response while req0 waits with its payload held.
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        set_req(1, 2'b10, 4'b0000, 64'hF0F0, 64'hFF00);
        #1;
        chk("bp_grant", W'(req_ready), W'(2));
        push_exp(1);
        @(posedge clk); #1;
        req_valid = 2'b01;
        set_req(0, 2'b10, 4'b0001, 64'h0F, 64'hF0);
        @(negedge clk);
        chk("bp_exec_ready", W'(req_ready), W'(0));
        @(negedge clk);
        check_rsp("bp", 1'b1);
        for (int c = 0; c < 5; c++) begin
            rsp_ready = (c < 3) ? 2'b00 : 2'b01;
            @(negedge clk);
            chk("bp_hold_valid", W'(rsp_valid), W'(2));
            chk("bp_hold_result", rsp_result, last_e.res);
            chk("bp_hold_ready", W'(req_ready), W'(0));
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("bp_done_valid", W'(rsp_valid), W'(0));
        chk("bp_waiter_grant", W'(req_ready), W'(1));
        push_exp(0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(6, ok);
        check_rsp("own0", ok);
        @(negedge clk);
        chk("own0_unowned_ready_held", W'(rsp_valid), W'(1));
        rsp_ready = 2'b01;
        @(negedge clk);
        chk("own0_done", W'(rsp_valid), W'(0));

        // LAT=3 instance: subtract to zero.
        set_req(0, 2'b01, 4'b0000, 64'd7, 64'd7);
        req_valid3 = 2'b01;
        rsp_ready3 = 2'b01;
        #1;
        chk("lat3_grant", W'(req_ready3), W'(1));
        push_exp(0);
        @(posedge clk); #1;
        req_valid3 = 2'b00;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("lat3_alu_a", alu_a3, W'(7));
            chk("lat3_alu_b", alu_b3, W'(7));
            chk("lat3_alu_aluop", W'(alu_aluop3), W'(1));
            chk("lat3_exec_rsp_valid", W'(rsp_valid3), W'(0));
        end
        @(negedge clk);
        last_e = sb.pop_front();
        chk("lat3_rsp_valid", W'(rsp_valid3), W'(1));
        chk("lat3_result", rsp_result3, last_e.res);
        chk("lat3_zero", W'(rsp_zero3), W'(last_e.zero));
        @(negedge clk);
        chk("lat3_rsp_drop", W'(rsp_valid3), W'(0));

        // Reset during EXEC after a req0 win: op dropped, req0 must still win next contest.
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        set_req(0, 2'b00, 4'b0000, 64'd1, 64'd2);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        req_valid = 2'b11;
        set_req(1, 2'b00, 4'b0000, 64'd40, 64'd2);
        @(negedge clk);
        chk("midrst_rsp_valid", W'(rsp_valid), W'(0));
        chk("midrst_req_ready", W'(req_ready), W'(0));
        chk("midrst_alu_a", alu_a, W'(0));
        chk("midrst_alu_b", alu_b, W'(0));
        chk("midrst_rsp_result", rsp_result, W'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_regrant", W'(req_ready), W'(1));
        push_exp(0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_rsp(6, ok);
        check_rsp("post_rst", ok);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
